rand_cell_picker: RTL and testbench

RAND_CELL_PICKER -- requirements
Module: rand_cell_picker

---
 rtl/rand_cell_picker.sv | 172 +++++++++++++++++
 tb/tb_rand_cell_picker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rand_cell_picker.sv
// rand_cell_picker
// Picks a free cell on a ROWS x COLS board, marks it occupied and reports it.
// Each random byte seen while searching gives one candidate (row from bits
// 6:4, column from bits 2:0). Out-of-range or occupied candidates are
// rejected. After MAX_TRIES rejections the search falls back to a linear
// scan of the board, one cell per cycle. This scan always finds a cell,
// because a search only starts while at least one cell is free.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   rand_in   random byte, a new value every cycle
//   req       pick request, sampled only while idle
//   clr       clear the occupancy map, sampled every cycle, beats req
//   busy      a pick is in progress (random sampling or fallback scan)
//   valid     one-cycle pulse, row/col hold a new pick
//   row, col  last picked cell, held until the next valid
//   fail      one-cycle pulse, request refused because the board is full
//   free_cnt  number of unoccupied cells
module rand_cell_picker #(
    parameter int ROWS      = 5,
    parameter int COLS      = 5,
    parameter int MAX_TRIES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rand_in,
    input  logic       req,
    input  logic       clr,
    output logic       busy,
    output logic       valid,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       fail,
    output logic [6:0] free_cnt
);

    localparam int CELLS = ROWS * COLS;

    typedef enum logic [1:0] {IDLE, SAMPLE, SCAN} state_t;

    state_t      state, state_next;

    // The map is kept at the full 64-cell width so that any 6-bit index can
    // address it directly. Bits at CELLS and above are never set.
    logic [63:0] occ;
    logic [7:0]  tries;
    logic [2:0]  scan_r, scan_c;

    logic [2:0]  cand_r, cand_c;
    logic [5:0]  cand_idx, scan_idx, pick_idx;
    logic        cand_ok;
    logic [2:0]  pick_r, pick_c;
    logic        accept, refuse, start, reject, to_scan, scan_adv;
    logic        unused_rand;

    assign cand_r      = rand_in[6:4];
    assign cand_c      = rand_in[2:0];
    assign unused_rand = rand_in[7] ^ rand_in[3];

    // The range test comes first. An out-of-range index may alias a real
    // cell, but the range test masks that cell.
    assign cand_idx = 6'(cand_r) * 6'(COLS) + 6'(cand_c);
    assign cand_ok  = ({1'b0, cand_r} < 4'(ROWS)) &&
                      ({1'b0, cand_c} < 4'(COLS)) && !occ[cand_idx];

    // The scan keeps row and column counters, so no divider is needed.
    assign scan_idx = 6'(scan_r) * 6'(COLS) + 6'(scan_c);

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        refuse     = 1'b0;
        start      = 1'b0;
        reject     = 1'b0;
        to_scan    = 1'b0;
        scan_adv   = 1'b0;
        pick_r     = cand_r;
        pick_c     = cand_c;
        pick_idx   = cand_idx;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (free_cnt != 7'd0) begin
                            start      = 1'b1;
                            state_next = SAMPLE;
                        end else begin
                            refuse = 1'b1;
                        end
                    end
                end
                SAMPLE: begin
                    if (cand_ok) begin
                        accept     = 1'b1;
                        state_next = IDLE;
                    end else if (tries == 8'(MAX_TRIES - 1)) begin
                        to_scan    = 1'b1;
                        state_next = SCAN;
                    end else begin
                        reject = 1'b1;
                    end
                end
                SCAN: begin
                    pick_r   = scan_r;
                    pick_c   = scan_c;
                    pick_idx = scan_idx;
                    if (!occ[scan_idx]) begin
                        accept     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        scan_adv = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= '0;
            free_cnt <= 7'(CELLS);
            tries    <= '0;
            scan_r   <= '0;
            scan_c   <= '0;
            valid    <= 1'b0;
            fail     <= 1'b0;
            row      <= '0;
            col      <= '0;
        end else begin
            // accept and refuse are already forced low by clr.
            valid <= accept;
            fail  <= refuse;

            if (clr) begin
                occ      <= '0;
                free_cnt <= 7'(CELLS);
            end else if (accept) begin
                occ[pick_idx] <= 1'b1;
                free_cnt      <= free_cnt - 7'd1;
                row           <= pick_r;
                col           <= pick_c;
            end

            if (start)       tries <= '0;
            else if (reject) tries <= tries + 8'd1;

            if (to_scan) begin
                scan_r <= '0;
                scan_c <= '0;
            end else if (scan_adv) begin
                if (scan_c == 3'(COLS - 1)) begin
                    scan_c <= '0;
                    scan_r <= scan_r + 3'd1;
                end else begin
                    scan_c <= scan_c + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rand_cell_picker.sv
// tb_rand_cell_picker
// Directed bench for rand_cell_picker with the default 5x5 board and
// MAX_TRIES = 64. A table of per-cycle vectors covers these cases:
//   - random picks, including rejected candidates
//   - back-to-back requests
//   - clr, including clr together with req
// Hand-written sequences then cover these cases:
//   - the fallback scan latency
//   - the scan wrapping from one row to the next
//   - a full board refusing a request
//   - reset arriving mid-scan
module tb_rand_cell_picker;

    logic       clk;
    logic       rst;
    logic [7:0] rand_in;
    logic       req;
    logic       clr;
    logic       busy;
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
    logic       fail;
    logic [6:0] free_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    rand_cell_picker dut (
        .clk      (clk),
        .rst      (rst),
        .rand_in  (rand_in),
        .req      (req),
        .clr      (clr),
        .busy     (busy),
        .valid    (valid),
        .row      (row),
        .col      (col),
        .fail     (fail),
        .free_cnt (free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic       clr;
        logic [7:0] rnd;
        logic       e_valid;
        logic       e_busy;
        logic       e_fail;
        logic [2:0] e_row;
        logic [2:0] e_col;
        logic [6:0] e_free;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 1'b0;
        clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // One random-path pick of a known-free cell: the req cycle, then the
    // sample cycle.
    task automatic pick(input logic [2:0] r, input logic [2:0] c, input string tag);
        req     = 1'b1;
        rand_in = {1'b0, r, 1'b0, c};
        tick();
        req = 1'b0;
        tick();
        check({tag, ".valid"}, 32'(valid), 32'd1);
        check({tag, ".row"}, 32'(row), 32'(r));
        check({tag, ".col"}, 32'(col), 32'(c));
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            tick();
            n++;
            if (valid) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rand_in = 8'h00;
        req     = 1'b0;
        clr     = 1'b0;
        rst     = 1'b0;

        // Vectors: inputs driven for one edge, outputs expected after it.
        tbl[0]  = '{1'b1, 1'b0, 8'h23, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 7'd25};
        tbl[1]  = '{1'b0, 1'b0, 8'h23, 1'b1, 1'b0, 1'b0, 3'd2, 3'd3, 7'd24};
        tbl[2]  = '{1'b1, 1'b0, 8'h23, 1'b0, 1'b1, 1'b0, 3'd2, 3'd3, 7'd24};
        tbl[3]  = '{1'b0, 1'b0, 8'h23, 1'b0, 1'b1, 1'b0, 3'd2, 3'd3, 7'd24};
        tbl[4]  = '{1'b0, 1'b0, 8'h14, 1'b1, 1'b0, 1'b0, 3'd1, 3'd4, 7'd23};
        tbl[5]  = '{1'b1, 1'b0, 8'h88, 1'b0, 1'b1, 1'b0, 3'd1, 3'd4, 7'd23};
        tbl[6]  = '{1'b1, 1'b0, 8'h88, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 7'd22};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 7'd22};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 7'd22};
        tbl[9]  = '{1'b0, 1'b0, 8'h45, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 7'd22};
        tbl[10] = '{1'b0, 1'b0, 8'h50, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 7'd22};
        tbl[11] = '{1'b0, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0, 3'd4, 3'd4, 7'd21};
        tbl[12] = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 3'd4, 3'd4, 7'd25};
        tbl[13] = '{1'b1, 1'b0, 8'h44, 1'b0, 1'b1, 1'b0, 3'd4, 3'd4, 7'd25};
        tbl[14] = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 3'd4, 3'd4, 7'd25};
        tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 3'd4, 7'd25};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 7'd24};
        tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 7'd24};

        do_reset();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.fail", 32'(fail), 32'd0);
        check("rst.row", 32'(row), 32'd0);
        check("rst.col", 32'(col), 32'd0);
        check("rst.free", 32'(free_cnt), 32'd25);

        for (int i = 0; i < 18; i++) begin
            req     = tbl[i].req;
            clr     = tbl[i].clr;
            rand_in = tbl[i].rnd;
            tick();
            check($sformatf("vec%0d.valid", i), 32'(valid), 32'(tbl[i].e_valid));
            check($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("vec%0d.fail", i), 32'(fail), 32'(tbl[i].e_fail));
            check($sformatf("vec%0d.row", i), 32'(row), 32'(tbl[i].e_row));
            check($sformatf("vec%0d.col", i), 32'(col), 32'(tbl[i].e_col));
            check($sformatf("vec%0d.free", i), 32'(free_cnt), 32'(tbl[i].e_free));
        end
        req = 1'b0;
        clr = 1'b0;

        // Candidate 8'h77 is never in range. There are 64 rejections, then
        // the scan takes cell 0 on the 65th edge after the req edge, so
        // valid shows in the 66th cycle.
        do_reset();
        req     = 1'b1;
        rand_in = 8'h77;
        tick();
        req = 1'b0;
        wait_valid(200, n);
        check("scan0.timeout", 32'(valid), 32'd1);
        check("scan0.edges", 32'(n), 32'd65);
        check("scan0.row", 32'(row), 32'd0);
        check("scan0.col", 32'(col), 32'd0);
        check("scan0.busy", 32'(busy), 32'd0);
        check("scan0.free", 32'(free_cnt), 32'd24);

        // Row 0 is fully occupied, so the scan must wrap into row 1. It
        // spends five extra edges on the occupied cells: 64 + 6 = 70.
        do_reset();
        for (int c = 0; c < 5; c++) pick(3'd0, 3'(c), $sformatf("row0_%0d", c));
        req     = 1'b1;
        rand_in = 8'h77;
        tick();
        req = 1'b0;
        wait_valid(200, n);
        check("scanwrap.timeout", 32'(valid), 32'd1);
        check("scanwrap.edges", 32'(n), 32'd70);
        check("scanwrap.row", 32'(row), 32'd1);
        check("scanwrap.col", 32'(col), 32'd0);
        check("scanwrap.free", 32'(free_cnt), 32'd19);

        // Fill the whole board, then a request must be refused.
        do_reset();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                pick(3'(r), 3'(c), $sformatf("fill%0d%0d", r, c));
        check("full.free", 32'(free_cnt), 32'd0);
        req     = 1'b1;
        rand_in = 8'h00;
        tick();
        req = 1'b0;
        check("full.fail", 32'(fail), 32'd1);
        check("full.valid", 32'(valid), 32'd0);
        check("full.busy", 32'(busy), 32'd0);
        tick();
        check("full.fail_pulse", 32'(fail), 32'd0);
        check("full.busy2", 32'(busy), 32'd0);
        check("full.valid2", 32'(valid), 32'd0);
        check("full.free2", 32'(free_cnt), 32'd0);

        // Cells 0..2 are occupied, so the scan is still running when reset
        // arrives.
        do_reset();
        for (int c = 0; c < 3; c++) pick(3'd0, 3'(c), $sformatf("pre%0d", c));
        req     = 1'b1;
        rand_in = 8'h77;
        tick();
        req = 1'b0;
        for (int k = 0; k < 65; k++) tick();
        check("midscan.busy", 32'(busy), 32'd1);
        check("midscan.novalid", 32'(valid), 32'd0);
        rst = 1'b1;
        req = 1'b1;
        tick();
        rst = 1'b0;
        req = 1'b0;
        check("rstscan.busy", 32'(busy), 32'd0);
        check("rstscan.valid", 32'(valid), 32'd0);
        check("rstscan.fail", 32'(fail), 32'd0);
        check("rstscan.row", 32'(row), 32'd0);
        check("rstscan.col", 32'(col), 32'd0);
        check("rstscan.free", 32'(free_cnt), 32'd25);
        tick();
        check("rstscan.valid2", 32'(valid), 32'd0);
        check("rstscan.busy2", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
